// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: widths, register address/word types and
// the hardwired-zero register address. Imported by the register file, its
// write decoder, the destination selector and the ALU.
package cpu_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 1 << ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] word_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : cpu_pkg

// File: rtl/reg_file_32x32_dec5x32.sv
// Write-address decoder for the register file: 5-to-32 one-hot write strobe,
// qualified by the write enable. Bit 0 is always low so r0 is never written.
module dec5x32
   import cpu_pkg::*;
(
   input  reg_addr_t        Wr,
   input  logic             We,
   output logic [NREG-1:0]  wstb
);

   // One-hot decode of the write address, gated by We, r0 strobe forced low.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      wstb = '0;
      if (We && (Wr != REG_ZERO)) begin
         wstb[Wr] = 1'b1;
      end
      wstb[0] = 1'b0;
   end

endmodule : dec5x32

// File: rtl/reg_file_32x32.sv
// General-purpose 32x32 register file: two combinational read ports (rs, rt),
// one clocked write port, r0 hardwired to zero, asynchronous active-low clear.
// Optional feature: define REGFILE_WR_BYPASS_EN to forward the write data
// straight to a read port that addresses the register being written.
module reg_file_32x32
   import cpu_pkg::*;
#(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int NREG   = cpu_pkg::NREG
)(
   input  logic              Clk,
   input  logic              Clrn,
   input  logic [ADDR_W-1:0] Ra,
   input  logic [ADDR_W-1:0] Rb,
   input  logic [ADDR_W-1:0] Wr,
   input  logic [DATA_W-1:0] D,
   input  logic              We,
   output logic [DATA_W-1:0] Qa,
   output logic [DATA_W-1:0] Qb
);

   // Storage exists for r1..r(NREG-1) only; r0 is a constant zero.
   logic [DATA_W-1:0] regs_q [1:NREG-1];
   logic [DATA_W-1:0] regs_d [1:NREG-1];
   logic [NREG-1:0]   wstb;
   logic [DATA_W-1:0] qa_stored;
   logic [DATA_W-1:0] qb_stored;

   dec5x32 u_dec (
      .Wr   (Wr),
      .We   (We),
      .wstb (wstb)
   );

   // Next-state of the array: the single strobed register takes D.
   always_comb begin
      regs_d = regs_q;
      for (int i = 1; i < NREG; i++) begin
         if (wstb[i]) begin
            regs_d[i] = D;
         end
      end
   end

   // Register array update; asynchronous clear wins over any write.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         // NOTE: this array is reset on purpose: software relies on every register reading zero after clear, so it cannot map to a reset-less RAM.
         for (int i = 1; i < NREG; i++) begin
            // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Stored-value read muxes; address 0 returns zero.
   always_comb begin
      qa_stored = '0;
      qb_stored = '0;
      if (Ra != REG_ZERO) qa_stored = regs_q[Ra];
      if (Rb != REG_ZERO) qb_stored = regs_q[Rb];
   end

`ifdef REGFILE_WR_BYPASS_EN
   // Write-through forwarding: a port reading the register being written sees D now.
   always_comb begin
      Qa = qa_stored;
      Qb = qb_stored;
      if (Clrn && We && (Wr != REG_ZERO)) begin
         if (Ra == Wr) Qa = D;
         if (Rb == Wr) Qb = D;
      end
   end
`else
   // No forwarding: ports return stored contents only.
   always_comb begin
      Qa = qa_stored;
      Qb = qb_stored;
   end
`endif

endmodule : reg_file_32x32

// File: tb/tb_reg_file_32x32.sv
// Self-checking bench for reg_file_32x32. A reference array tracks register
// contents; each read pushes expected Qa/Qb onto a scoreboard queue, which is
// popped and compared once the combinational outputs have settled.
module tb_reg_file_32x32;

   logic        Clk;
   logic        Clrn;
   logic [4:0]  Ra, Rb, Wr;
   logic [31:0] D;
   logic        We;
   logic [31:0] Qa, Qb;

   int errors = 0;
   int checks = 0;

   logic [31:0] model [0:31];

   typedef struct {
      string       name;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } sb_entry_t;

   sb_entry_t sb_q[$];

   reg_file_32x32 dut (
      .Clk  (Clk),
      .Clrn (Clrn),
      .Ra   (Ra),
      .Rb   (Rb),
      .Wr   (Wr),
      .D    (D),
      .We   (We),
      .Qa   (Qa),
      .Qb   (Qb)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // We must never be unknown while out of reset.
   always @(negedge Clk) begin
      if (Clrn === 1'b1) begin
         checks++;
         if ($isunknown(We)) begin
            errors++;
            $display("FAIL we_known: We=%b while Clrn=1, required 0 or 1", We);
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Expected read value for an address given current inputs and model.
   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
`ifdef REGFILE_WR_BYPASS_EN
      if (Clrn === 1'b1 && We === 1'b1 && Wr != 5'd0 && a == Wr) return D;
`endif
      return model[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   // Drive read addresses, push expectation, let outputs settle, pop and compare.
   task automatic do_read(input string name, input logic [4:0] ra, input logic [4:0] rb);
      sb_entry_t e;
      Ra = ra;
      Rb = rb;
      #0;
      e.name  = name;
      e.exp_a = exp_read(ra);
      e.exp_b = exp_read(rb);
      sb_q.push_back(e);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (Qa !== e.exp_a) begin
         errors++;
         $display("FAIL %s Qa(Ra=%0d): got %h expected %h", e.name, ra, Qa, e.exp_a);
      end
      checks++;
      if (Qb !== e.exp_b) begin
         errors++;
         $display("FAIL %s Qb(Rb=%0d): got %h expected %h", e.name, rb, Qb, e.exp_b);
      end
   endtask

   // One write cycle: drive at negedge, commit at posedge, release We afterwards.
   task automatic do_write(input logic [4:0] wr, input logic [31:0] d, input logic we);
      @(negedge Clk);
      We = we;
      Wr = wr;
      D  = d;
      @(posedge Clk);
      if (Clrn === 1'b1 && we && wr != 5'd0) model[wr] = d;
      #1;
      We = 1'b0;
   endtask

   task automatic read_all(input string name);
      for (int i = 0; i < 32; i++) do_read(name, 5'(i), 5'(31 - i));
   endtask

   task automatic test_reset();
      read_all("reset_state");
      do_write(5'd5, 32'hDEADBEEF, 1'b1);
      do_read("pre_clear_r5", 5'd5, 5'd5);
      @(negedge Clk);
      #2;
      Clrn = 1'b0;
      clear_model();
      do_read("async_clear_r5", 5'd5, 5'd5);
      #1;
      Clrn = 1'b1;
      do_read("after_clear_r5", 5'd5, 5'd0);
   endtask

   task automatic test_basic_write();
      do_write(5'd7, 32'h12345678, 1'b1);
      do_read("basic_r7", 5'd7, 5'd7);
      read_all("basic_others");
      do_write(5'd31, 32'hCAFEF00D, 1'b1);
      do_write(5'd1,  32'h80000001, 1'b1);
      do_read("edge_regs", 5'd31, 5'd1);
   endtask

   task automatic test_r0_protect();
      do_write(5'd0, 32'hFFFFFFFF, 1'b1);
      read_all("r0_protect");
      @(negedge Clk);
      We = 1'b1; Wr = 5'd0; D = 32'hFFFFFFFF;
      do_read("r0_no_bypass", 5'd0, 5'd0);
      We = 1'b0;
   endtask

   task automatic test_we_low();
      do_write(5'd3, 32'hA5A5A5A5, 1'b1);
      do_write(5'd3, 32'h00000000, 1'b0);
      do_read("we_low_r3", 5'd3, 5'd3);
   endtask

   task automatic test_same_addr();
      do_write(5'd9, 32'h1, 1'b1);
      @(negedge Clk);
      We = 1'b1; Wr = 5'd9; D = 32'h2;
      do_read("same_addr_before", 5'd9, 5'd7);
      @(posedge Clk);
      model[9] = 32'h2;
      #1;
      We = 1'b0;
      do_read("same_addr_after", 5'd9, 5'd9);
   endtask

   task automatic test_back_to_back();
      for (int i = 10; i < 16; i++) do_write(5'(i), 32'h1000_0000 + 32'(i * 3), 1'b1);
      for (int i = 10; i < 16; i++) do_read("b2b", 5'(i), 5'(25 - i));
   endtask

   task automatic test_reset_vs_write();
      do_write(5'd4, 32'h11, 1'b1);
      @(negedge Clk);
      Clrn = 1'b0;
      clear_model();
      We = 1'b1; Wr = 5'd4; D = 32'h55;
      do_read("rst_bypass_off", 5'd4, 5'd4);
      @(posedge Clk);
      #1;
      @(negedge Clk);
      We = 1'b0;
      Clrn = 1'b1;
      do_read("rst_vs_write_r4", 5'd4, 5'd9);
   endtask

   initial begin
      Clrn = 1'b0;
      We   = 1'b0;
      Wr   = 5'd0;
      D    = 32'h0;
      Ra   = 5'd0;
      Rb   = 5'd0;
      clear_model();
      repeat (3) @(negedge Clk);
      Clrn = 1'b1;

      test_reset();
      test_basic_write();
      test_r0_protect();
      test_we_low();
      test_same_addr();
      test_back_to_back();
      test_reset_vs_write();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_reg_file_32x32
